// File: rtl/mod_mem_load_unit_pkg.sv
// Shared types and helpers for the load unit.
`include "system_defines.svh"

package mod_mem_load_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } load_state_e;

    // True when the request must not reach memory: unknown funct3 or an
    // address that is not naturally aligned for the access size.
    function automatic logic is_misaligned(input logic [`FUNCT3_WIDTH-1:0] funct3,
                                           input logic [1:0]               offset);
        logic bad;
        bad = 1'b1;
        case (funct3)
            `FUNCT3_LB, `FUNCT3_LBU: bad = 1'b0;
            `FUNCT3_LH, `FUNCT3_LHU: bad = offset[0];
            `FUNCT3_LW:              bad = (offset != 2'b00);
            default:                 bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mod_mem_load_unit_if.sv
// Data-memory read bus between the load unit (master) and memory (slave).
`include "system_defines.svh"

interface mod_mem_load_unit_if;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [`XLEN-1:0] mem_addr;
    logic             mem_rsp_valid;
    logic [`XLEN-1:0] mem_rsp_data;
    logic             mem_rsp_error;

    modport master (
        output mem_req_valid, mem_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_error
    );

    modport slave (
        input  mem_req_valid, mem_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_error
    );
endinterface

// File: rtl/mod_mem_load_data_extractor.sv
// Selects the byte/halfword lane of a loaded word and extends it to XLEN.
`include "system_defines.svh"

module mod_mem_load_data_extractor (
    input  logic [`FUNCT3_WIDTH-1:0] funct3_i,
    input  logic [1:0]               offset_i,
    input  logic [`XLEN-1:0]         word_i,
    output logic [`XLEN-1:0]         data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by sign or zero extension
    always_comb begin
        byte_sel = 8'(word_i >> {offset_i, 3'b000});
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            `FUNCT3_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            `FUNCT3_LBU: data_o = {24'h000000, byte_sel};
            `FUNCT3_LH:  data_o = {{16{half_sel[15]}}, half_sel};
            `FUNCT3_LHU: data_o = {16'h0000, half_sel};
            default:     data_o = word_i;
        endcase
    end
endmodule

// File: rtl/system_defines.svh
// System-wide widths and encodings shared by the load/store units.
`ifndef SYSTEM_DEFINES_SVH
`define SYSTEM_DEFINES_SVH

`define XLEN          32
`define FUNCT3_WIDTH  3

// Store funct3 encodings
`define FUNCT3_SB     3'b000
`define FUNCT3_SH     3'b001
`define FUNCT3_SW     3'b010

// Load funct3 encodings
`define FUNCT3_LB     3'b000
`define FUNCT3_LH     3'b001
`define FUNCT3_LW     3'b010
`define FUNCT3_LBU    3'b100
`define FUNCT3_LHU    3'b101

// Load/store exception codes
`define EXC_NONE      2'd0
`define EXC_MISALIGN  2'd1
`define EXC_ACCESS    2'd2
`define EXC_TIMEOUT   2'd3

`endif

// File: rtl/mod_mem_load_unit.sv
// Load unit: accepts a load, issues an aligned word read, extracts and
// extends the result, and reports misalignment, access faults and timeouts.
`include "system_defines.svh"

module mod_mem_load_unit
    import mod_mem_load_unit_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT_CYCLES = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [`FUNCT3_WIDTH-1:0] funct3_i,
    input  logic [`XLEN-1:0]         address_i,
    input  logic [4:0]               rd_i,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic [`XLEN-1:0]         mem_addr_o,
    input  logic                     mem_rsp_valid_i,
    input  logic [`XLEN-1:0]         mem_rsp_data_i,
    input  logic                     mem_rsp_error_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [`XLEN-1:0]         rsp_data_o,
    output logic [4:0]               rsp_rd_o,
    output logic [1:0]               rsp_exception_o,
    output logic                     busy_o
);
    load_state_e              state_q, state_d;
    logic [`FUNCT3_WIDTH-1:0] funct3_q, funct3_d;
    logic [1:0]               offset_q, offset_d;
    logic [`XLEN-3:0]         addr_q, addr_d;
    logic [4:0]               rd_q, rd_d;
    logic [`XLEN-1:0]         data_q, data_d;
    logic [1:0]               exc_q, exc_d;
    logic [31:0]              cnt_q, cnt_d;
    logic [`XLEN-1:0]         extracted;

    mod_mem_load_data_extractor u_extractor (
        .funct3_i (funct3_q),
        .offset_i (offset_q),
        .word_i   (mem_rsp_data_i),
        .data_o   (extracted)
    );

    // State and captured-field registers; reset abandons any access
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            funct3_q <= '0;
            offset_q <= '0;
            addr_q   <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            exc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            offset_q <= offset_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            exc_q    <= exc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d         = state_q;
        funct3_d        = funct3_q;
        offset_d        = offset_q;
        addr_d          = addr_q;
        rd_d            = rd_q;
        data_d          = data_q;
        exc_d           = exc_q;
        cnt_d           = cnt_q;
        req_ready_o     = 1'b0;
        mem_req_valid_o = 1'b0;
        rsp_valid_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    funct3_d = funct3_i;
                    offset_d = address_i[1:0];
                    addr_d   = address_i[`XLEN-1:2];
                    rd_d     = rd_i;
                    data_d   = '0;
                    cnt_d    = '0;
                    if (is_misaligned(funct3_i, address_i[1:0])) begin
                        exc_d   = `EXC_MISALIGN;
                        state_d = ST_RESP;
                    end else begin
                        exc_d   = `EXC_NONE;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response in the same cycle as the timeout still wins
                if (mem_rsp_valid_i) begin
                    data_d  = mem_rsp_error_i ? '0 : extracted;
                    exc_d   = mem_rsp_error_i ? `EXC_ACCESS : `EXC_NONE;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if (MEM_TIMEOUT_CYCLES != 0 && cnt_d == 32'(MEM_TIMEOUT_CYCLES)) begin
                        data_d  = '0;
                        exc_d   = `EXC_TIMEOUT;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_addr_o      = {addr_q, 2'b00};
    assign rsp_data_o      = data_q;
    assign rsp_rd_o        = rd_q;
    assign rsp_exception_o = exc_q;
    assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: doc/mod_mem_load_unit.md
MOD_MEM_LOAD_UNIT -- requirements
Module: mod_mem_load_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT_CYCLES, default 255: WAIT cycles before timeout; 0 disables timeout.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports req_valid_i (input, 1) and req_ready_o (output, 1): pipeline load-request handshake.
REQ-005 SHALL have ports funct3_i (input, `FUNCT3_WIDTH), address_i (input, `XLEN) and rd_i (input, 5): load type, unaligned byte address and destination register tag.
REQ-006 SHALL have ports mem_req_valid_o (output, 1), mem_req_ready_i (input, 1) and mem_addr_o (output, `XLEN): data-memory read request.
REQ-007 SHALL have ports mem_rsp_valid_i (input, 1), mem_rsp_data_i (input, `XLEN) and mem_rsp_error_i (input, 1): memory read response.
REQ-008 SHALL have ports rsp_valid_o (output, 1), rsp_ready_i (input, 1), rsp_data_o (output, `XLEN), rsp_rd_o (output, 5) and rsp_exception_o (output, 2): result to writeback.
REQ-009 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-010 SHALL implement the FSM states IDLE, REQ, WAIT and RESP.
REQ-011 SHALL drive req_ready_o high only in IDLE; on req_valid_i&&req_ready_o it SHALL capture funct3, address[1:0] and rd.
REQ-012 SHALL accept LB=000, LH=001, LW=010, LBU=100 and LHU=101 as legal funct3 values.
REQ-013 SHALL treat as misaligned: LH/LHU with address[0]=1, LW with address[1:0]!=0, and any other funct3; such a request SHALL go IDLE->RESP with exception 1 and data 0, and SHALL NOT assert mem_req_valid_o.
REQ-014 SHALL take an aligned request IDLE->REQ, with mem_req_valid_o=1 and mem_addr_o={address[31:2],2'b00} held stable until mem_req_ready_i.
REQ-015 SHALL go REQ->WAIT on the memory handshake.
REQ-016 SHALL, in WAIT on mem_rsp_valid_i, register the extracted data and go to RESP; mem_rsp_valid_i outside WAIT SHALL be ignored.
REQ-017 SHALL extract byte lane = offset for LB/LBU and halfword = offset[1] for LH/LHU, with sign extension for LB/LH and zero extension for LBU/LHU; LW passes the word through unchanged.
REQ-018 SHALL report exception 2 with data 0 when mem_rsp_error_i=1 with the response.
REQ-019 SHALL count WAIT cycles; when MEM_TIMEOUT_CYCLES!=0 and the count reaches it, it SHALL go to RESP with exception 3 and data 0, and a later stale response SHALL be ignored.
REQ-020 SHALL hold rsp_valid_o=1 with stable data/rd/exception in RESP until rsp_ready_i, then return to IDLE.
REQ-021 SHALL use exception codes 0=none, 1=misaligned/illegal, 2=access fault, 3=timeout.
REQ-022 SHALL give zero-wait memory a latency of 3 cycles from the accept edge to rsp_valid_o (REQ, WAIT, RESP); the next request is accepted no earlier than the cycle after the RESP handshake.

Reset
REQ-023 SHALL, while rst_ni=0, force state IDLE and the timeout counter and all registered fields to 0.
REQ-024 SHALL, in reset, drive outputs req_ready_o=1, mem_req_valid_o=0, rsp_valid_o=0, busy_o=0 and mem_addr_o, rsp_data_o, rsp_rd_o, rsp_exception_o = 0.
REQ-025 SHALL abandon any in-flight access on reset mid-operation; a memory response arriving after reset release SHALL be ignored.

Structure
REQ-026 SHALL define the load funct3 constants (FUNCT3_LB/LH/LW/LBU/LHU) and the exception-code constants in system_defines.svh beside the existing store constants.
REQ-027 SHALL place byte/half extraction and extension in one combinational sub-module, mod_mem_load_data_extractor (funct3, offset, word in; extended value out).

Verification
REQ-028 SHALL cover: LB @0x1003, word 0x80FF7F01 -> rsp_data_o 0xFFFFFF80, exc 0; LBU @0x1003 -> 0x00000080; LB @0x1000 -> 0x00000001.
REQ-029 SHALL cover: LH @0x1002, word 0x80011234 -> 0xFFFF8001; LHU @0x1002 -> 0x00008001; LW @0x1000 -> 0x80011234, mem_addr_o 0x1000.
REQ-030 SHALL cover: LW @0x1001 and funct3=011 -> exc 1, data 0, mem_req_valid_o never asserted.
REQ-031 SHALL cover: MEM_TIMEOUT_CYCLES=4, no response -> exc 3 after 4 WAIT cycles; a response on the following cycle is ignored and the FSM is IDLE.
REQ-032 SHALL cover: mem_req_ready_i low for 3 cycles and rsp_ready_i low for 2 cycles -> mem_addr_o and rsp_* held stable, req_ready_o=0 throughout.
REQ-033 SHALL cover: rst_ni pulsed low in WAIT -> outputs at reset values immediately; the late mem_rsp_valid_i produces no rsp_valid_o.
